enc4x2_rr: RTL and testbench
============================

# enc4x2_rr

Sequential 4-to-2 encoder; the inverse of the team's 2-to-4 decoder. Accepts a 4-line request vector through a valid/ready handshake and captures every set line. It then emits one 2-bit code per set line, in round-robin order, through a second valid/ready handshake. Feeding it any decoder output o returns the original select value s. It sits between line-per-event sources (decoders, interrupt lines) and code-consuming logic.

## Interface
- Parameters: none; widths come from package constants N_LINES=4, CODE_W=2.
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request vector o is valid
- in_ready  out  1  block can accept a vector; high exactly when the FSM is IDLE
- o  in  4  request lines; o[k] set means line k requests
- s_valid  out  1  code s is valid
- s_ready  in  1  consumer accepts s
- s  out  2  encoded line number; value = s[0]*1 + s[1]*2 (same mapping as the decoder's select)
- multi  out  1  registered at accept: more than one line was set in the accepted vector
- err  out  1  one-cycle pulse: an all-zero vector was accepted

## Operation
- State:
  - pend[3:0]: pending lines.
  - ptr[1:0]: round-robin start position.
  - FSM states {IDLE, SERVE}.
- IDLE, in_valid=1:
  - pend<=o; multi<=(popcount(o)>1).
  - If o≠0: go to SERVE; s<=pick(o,ptr); s_valid<=1.
  - If o=0: stay IDLE; err<=1 for one cycle; no code is emitted; multi<=0.
- pick(p,ptr): first set bit of p searching ptr, ptr+1, ... mod 4; wraps 3→0.
- SERVE, s_valid&&s_ready with current code k:
  - pend bit k cleared; ptr<=k+1 mod 4.
  - If other bits remain: s<=pick(remaining,k+1); s_valid stays 1.
  - Otherwise: s_valid<=0; go to IDLE.
- SERVE, s_valid&&!s_ready: s, s_valid, pend, ptr hold stable; no drop, no change.
- in_valid is ignored outside IDLE (in_ready=0); o is don't-care when in_valid=0.
- ptr persists across vectors (fairness across requests); only reset clears it.
- Reset values: FSM=IDLE, pend=0, ptr=0, s=2'b00, s_valid=0, multi=0, err=0; in_ready=1 from the first cycle after reset.
- Reset mid-SERVE: pending codes are discarded; the reset values above hold on the next cycle.

## Timing
- Accept at edge T (in_valid&&in_ready) → s_valid=1 with first code in cycle T+1.
- Throughput: one code per cycle while s_ready=1; a vector with n set lines takes n cycles in SERVE.
- After the last handshake at edge T: s_valid=0 and in_ready=1 in cycle T+1.
- Back-to-back throughput: 1 vector per (n+1) cycles.
- Outputs are registered, except in_ready, which is decoded from FSM state only (no combinational path from in_valid or s_ready).
- err: high only in the cycle after a zero-vector accept.
- multi: holds until the next accept or reset.

## Structure
- Package enc_pkg:
  - N_LINES, CODE_W constants.
  - FSM state enum {IDLE, SERVE}.
- Sub-module rr_pick4 (combinational):
  - Inputs: pend[3:0], ptr[1:0].
  - Outputs: code[1:0], found.
  - Instantiated once, fed either o (at accept) or pend with the granted bit masked (at handshake).
- Top level contains the FSM, the pend/ptr/s/multi/err registers and the handshake logic.

## Test plan
- Round trip: after reset, present each decoder output for s=0..3 (o[0], o[1], o[2], o[3] alone) with s_ready=1 → s=0,1,2,3 respectively, one cycle after accept; multi=0; in_ready=1 two cycles after each accept.
- All lines: o=all ones with ptr=0 and s_ready=1 → codes 0,1,2,3 on four consecutive cycles; multi=1; ptr=0 afterwards; in_ready=1 the cycle after the fourth handshake.
- Backpressure: o[1] and o[3] set, s_ready=0 for 3 cycles → s=1 held stable with s_valid=1; then s_ready=1 → codes 1 then 3, then s_valid=0.
- Round-robin wrap: o[2] alone is served (ptr becomes 3); then o[0] and o[3] set → order 3 then 0; ptr ends at 1.
- Zero vector: accept o=0 → err=1 for exactly one cycle; s_valid stays 0; in_ready stays 1; multi=0.
- Reset mid-SERVE: accept o[0],o[1],o[2] set, assert reset after the first handshake → next cycle s_valid=0, in_ready=1, s=0, multi=0; a following o[3] vector yields s=3 (ptr=0 search).

Source files
------------

// File: rtl/enc4x2_rr_pkg.sv
// Shared constants, FSM encoding and a population-count helper for the
// sequential round-robin 4-to-2 encoder.
package enc_pkg;

    localparam int unsigned N_LINES = 4;
    localparam int unsigned CODE_W  = 2;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } enc_state_e;

    // Number of set lines in a request vector.
    function automatic logic [CNT_W-1:0] popcount4(input logic [N_LINES-1:0] p);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(N_LINES); i++) begin
            cnt = cnt + CNT_W'(p[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/enc4x2_rr_if.sv
// Request-side and code-side handshakes of the encoder bundled together.
interface enc4x2_rr_if;
    import enc_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [N_LINES-1:0]   o;
    logic                 s_valid;
    logic                 s_ready;
    logic [CODE_W-1:0]    s;
    logic                 multi;
    logic                 err;

    modport master (
        output in_valid, o, s_ready,
        input  in_ready, s_valid, s, multi, err
    );

    modport slave (
        input  in_valid, o, s_ready,
        output in_ready, s_valid, s, multi, err
    );
endinterface

// File: rtl/enc4x2_rr_rr_pick4.sv
// Round-robin picker: first set bit of pend starting at ptr, wrapping 3->0.
module rr_pick4
    import enc_pkg::*;
(
    input  logic [N_LINES-1:0] pend,
    input  logic [CODE_W-1:0]  ptr,
    output logic [CODE_W-1:0]  code,
    output logic               found
);

    logic [CODE_W-1:0] idx;

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        code  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
            idx = ptr + CODE_W'(i);
            if (pend[idx]) begin
                code  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enc4x2_rr.sv
// Sequential 4-to-2 encoder: captures a request vector, then emits one code
// per set line in round-robin order over a valid/ready handshake.
module enc4x2_rr
    import enc_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    enc4x2_rr_if.slave    bus
);

    enc_state_e          state_q, state_d;
    logic [N_LINES-1:0]  pend_q, pend_d;
    logic [CODE_W-1:0]   ptr_q, ptr_d;
    logic [CODE_W-1:0]   s_q, s_d;
    logic                s_valid_q, s_valid_d;
    logic                multi_q, multi_d;
    logic                err_q, err_d;

    logic [N_LINES-1:0]  pend_left;
    logic [CODE_W-1:0]   ptr_next;
    logic [N_LINES-1:0]  pick_pend;
    logic [CODE_W-1:0]   pick_ptr;
    logic [CODE_W-1:0]   pick_code;
    logic                pick_found;

    // Pending set after the current code is granted, and the search start after it.
    assign pend_left = pend_q & ~(N_LINES'(1) << s_q);
    assign ptr_next  = CODE_W'(s_q + CODE_W'(1));

    // One picker shared between accept (fresh vector) and handshake (remaining lines).
    assign pick_pend = (state_q == IDLE) ? bus.o  : pend_left;
    assign pick_ptr  = (state_q == IDLE) ? ptr_q  : ptr_next;

    rr_pick4 u_pick (
        .pend  (pick_pend),
        .ptr   (pick_ptr),
        .code  (pick_code),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            ptr_q     <= '0;
            s_q       <= '0;
            s_valid_q <= 1'b0;
            multi_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            s_q       <= s_d;
            s_valid_q <= s_valid_d;
            multi_q   <= multi_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        ptr_d     = ptr_q;
        s_d       = s_q;
        s_valid_d = s_valid_q;
        multi_d   = multi_q;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    pend_d  = bus.o;
                    multi_d = (popcount4(bus.o) > CNT_W'(1));
                    if (pick_found) begin
                        state_d   = SERVE;
                        s_d       = pick_code;
                        s_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (s_valid_q && bus.s_ready) begin
                    pend_d = pend_left;
                    ptr_d  = ptr_next;
                    if (pick_found) begin
                        s_d = pick_code;
                    end else begin
                        s_valid_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.s_valid  = s_valid_q;
    assign bus.s        = s_q;
    assign bus.multi    = multi_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_enc4x2_rr.sv
// Bench for enc4x2_rr: directed literal checks plus randomized traffic
// compared every cycle against a queue-based model of the code sequence.
module tb_enc4x2_rr;

    logic clk;
    logic reset;

    enc4x2_rr_if bus ();

    enc4x2_rr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model: the codes still owed for the current vector, in emission order.
    int q[$];
    int m_ptr   = 0;
    bit m_multi = 1'b0;
    bit m_err   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // A vector's codes are its set lines in cyclic order starting at ptr.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_ptr   = 0;
            m_multi = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            if (q.size() == 0 && bus.in_valid) begin
                int cnt;
                cnt = 0;
                for (int j = 0; j < 4; j++) begin
                    int line;
                    line = (m_ptr + j) % 4;
                    if (bus.o[line]) begin
                        q.push_back(line);
                        cnt++;
                    end
                end
                m_multi = (cnt > 1);
                m_err   = (cnt == 0);
            end else if (q.size() != 0 && bus.s_ready) begin
                m_ptr = (q[0] + 1) % 4;
                void'(q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", int'(bus.in_ready), int'(q.size() == 0));
            check("s_valid",  int'(bus.s_valid),  int'(q.size() != 0));
            if (q.size() != 0) check("s", int'(bus.s), q[0]);
            check("multi", int'(bus.multi), int'(m_multi));
            check("err",   int'(bus.err),   int'(m_err));
        end
    end

    task automatic step(input bit rst, input bit iv, input logic [3:0] ov, input bit sr);
        reset        = rst;
        bus.in_valid = iv;
        bus.o        = ov;
        bus.s_ready  = sr;
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.o        = '0;
        bus.s_ready  = 1'b0;
        repeat (2) @(negedge clk);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        chk_en = 1'b1;

        check("rst_s",        int'(bus.s),        0);
        check("rst_s_valid",  int'(bus.s_valid),  0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_multi",    int'(bus.multi),    0);
        check("rst_err",      int'(bus.err),      0);

        // Round trip: single-line vectors decode back to their select value.
        for (int k = 0; k < 4; k++) begin
            logic [3:0] one;
            one = 4'(1 << k);
            step(1'b0, 1'b1, one, 1'b1);
            check("rt_s",        int'(bus.s),        k);
            check("rt_s_valid",  int'(bus.s_valid),  1);
            check("rt_multi",    int'(bus.multi),    0);
            check("rt_in_ready", int'(bus.in_ready), 0);
            step(1'b0, 1'b0, 4'h0, 1'b1);
            check("rt_idle", int'(bus.in_ready), 1);
        end

        // All lines from ptr=0.
        step(1'b0, 1'b1, 4'hf, 1'b1);
        check("all_s0",    int'(bus.s),     0);
        check("all_multi", int'(bus.multi), 1);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("all_s1", int'(bus.s), 1);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("all_s2", int'(bus.s), 2);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("all_s3", int'(bus.s), 3);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("all_in_ready", int'(bus.in_ready), 1);
        check("all_s_valid",  int'(bus.s_valid),  0);

        // Backpressure holds the first code.
        step(1'b0, 1'b1, 4'b1010, 1'b0);
        check("bp_s0", int'(bus.s), 1);
        repeat (3) begin
            step(1'b0, 1'b0, 4'h0, 1'b0);
            check("bp_hold_s",     int'(bus.s),       1);
            check("bp_hold_valid", int'(bus.s_valid), 1);
        end
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("bp_s1", int'(bus.s), 3);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("bp_done", int'(bus.s_valid), 0);

        // Wrap: line 2 moves ptr to 3, so {0,3} is served 3 then 0; ptr ends at 1.
        step(1'b0, 1'b1, 4'b0100, 1'b1);
        check("wr_s2", int'(bus.s), 2);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b1, 4'b1001, 1'b1);
        check("wr_first", int'(bus.s), 3);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("wr_second", int'(bus.s), 0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b1, 4'b0011, 1'b1);
        check("wr_ptr1", int'(bus.s), 1);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("wr_ptr1_next", int'(bus.s), 0);
        step(1'b0, 1'b0, 4'h0, 1'b1);

        // Zero vector.
        step(1'b0, 1'b1, 4'h0, 1'b1);
        check("zv_err",      int'(bus.err),      1);
        check("zv_s_valid",  int'(bus.s_valid),  0);
        check("zv_in_ready", int'(bus.in_ready), 1);
        check("zv_multi",    int'(bus.multi),    0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("zv_err_drop", int'(bus.err), 0);

        // Reset after the first handshake of a three-line vector (ptr=1 here).
        step(1'b0, 1'b1, 4'b0111, 1'b1);
        check("rm_s0", int'(bus.s), 1);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("rm_s1", int'(bus.s), 2);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        check("rm_s_valid",  int'(bus.s_valid),  0);
        check("rm_in_ready", int'(bus.in_ready), 1);
        check("rm_s",        int'(bus.s),        0);
        check("rm_multi",    int'(bus.multi),    0);
        step(1'b0, 1'b1, 4'b1000, 1'b1);
        check("rm_after", int'(bus.s), 3);
        step(1'b0, 1'b0, 4'h0, 1'b1);

        // Randomized traffic against the model.
        repeat (3000) begin
            step(($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        step(1'b0, 1'b0, 4'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
